// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversampling constants and the
// 2-of-3 majority voter. The transmit side reuses this package.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DATA_W     = 8;
  localparam int unsigned TCNT_W     = 4;
  localparam int unsigned BITCNT_W   = 3;

  // Tick indices within one bit period.
  localparam logic [TCNT_W-1:0] TICK_SMP0 = 4'd7;
  localparam logic [TCNT_W-1:0] TICK_SMP1 = 4'd8;
  localparam logic [TCNT_W-1:0] TICK_SMP2 = 4'd9;
  localparam logic [TCNT_W-1:0] TICK_STOP = 4'd9;
  localparam logic [TCNT_W-1:0] TICK_LAST = 4'd15;

  typedef enum logic [2:0] {
    S_LINE  = 3'd0,
    S_IDLE  = 3'd1,
    S_START = 3'd2,
    S_DATA  = 3'd3,
    S_STOP  = 3'd4
  } rx_state_e;

  function automatic logic maj3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: the serial pin in, decoded byte and status strobes out.
interface uart_rx_if;
  import uart_pkg::*;

  logic              rx;
  logic [DATA_W-1:0] rx_byte;
  logic              received;
  logic              is_receiving;
  logic              recv_error;

  modport master (
    input  rx,
    output rx_byte, received, is_receiving, recv_error
  );

  modport slave (
    output rx,
    input  rx_byte, received, is_receiving, recv_error
  );

endinterface

// File: rtl/baud_tick_gen.sv
// Oversampling tick generator: one-cycle tick every DIV clocks, restartable via clear.
module baud_tick_gen #(
  parameter int unsigned DIV = 325
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_W'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, 2-of-3 majority bit decision, framing check
// at mid stop bit so a back-to-back start bit is never missed.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 50_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.master bus
);

  localparam int unsigned DIV = CLK_FREQ / (BAUD * OVERSAMPLE);

  rx_state_e             state_q, state_d;
  logic [1:0]            sync_q, sync_d;
  logic [TCNT_W-1:0]     tcnt_q, tcnt_d;
  logic [BITCNT_W-1:0]   bitcnt_q, bitcnt_d;
  logic [DATA_W-1:0]     shreg_q, shreg_d;
  logic [2:0]            smp_q, smp_d;
  logic [DATA_W-1:0]     rx_byte_q, rx_byte_d;
  logic                  received_q, received_d;
  logic                  is_receiving_q, is_receiving_d;
  logic                  recv_error_q, recv_error_d;
  logic                  rxs;
  logic                  tick;
  logic                  clear_c;
  logic                  bit_c;
  logic                  stop_c;
  logic                  in_frame_q_c, in_frame_d_c;

  assign rxs = sync_q[1];

  baud_tick_gen #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (clear_c),
    .tick  (tick)
  );

  // Bit value from the three stored samples; the stop decision uses the live 9th sample.
  assign bit_c  = maj3(smp_q);
  assign stop_c = maj3({rxs, smp_q[1:0]});

  assign in_frame_q_c = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
  assign in_frame_d_c = (state_d == S_START) || (state_d == S_DATA) || (state_d == S_STOP);

  always_comb begin
    state_d      = state_q;
    sync_d       = {sync_q[0], bus.rx};
    tcnt_d       = tcnt_q;
    bitcnt_d     = bitcnt_q;
    shreg_d      = shreg_q;
    smp_d        = smp_q;
    rx_byte_d    = rx_byte_q;
    received_d   = 1'b0;
    recv_error_d = 1'b0;
    clear_c      = 1'b0;

    if (tick) begin
      tcnt_d = tcnt_q + TCNT_W'(1);
      if (tcnt_q == TICK_SMP0) smp_d[0] = rxs;
      if (tcnt_q == TICK_SMP1) smp_d[1] = rxs;
      if (tcnt_q == TICK_SMP2) smp_d[2] = rxs;
    end

    unique case (state_q)
      // Sampled on a tick so the synchronizer's reset value is never trusted.
      S_LINE: begin
        if (tick && rxs) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          clear_c = 1'b1;
          tcnt_d  = '0;
        end
      end
      S_START: begin
        if (tick && (tcnt_q == TICK_LAST)) begin
          if (bit_c) begin
            state_d = S_IDLE;
          end else begin
            state_d  = S_DATA;
            bitcnt_d = '0;
          end
        end
      end
      S_DATA: begin
        if (tick && (tcnt_q == TICK_LAST)) begin
          shreg_d  = {bit_c, shreg_q[DATA_W-1:1]};
          bitcnt_d = bitcnt_q + BITCNT_W'(1);
          if (bitcnt_q == BITCNT_W'(DATA_W - 1)) state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick && (tcnt_q == TICK_STOP)) begin
          if (stop_c) begin
            rx_byte_d  = shreg_q;
            received_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            recv_error_d = 1'b1;
            state_d      = S_LINE;
          end
        end
      end
      default: state_d = S_LINE;
    endcase

    // Rises one clock after frame start, drops on the same edge as the strobe.
    is_receiving_d = in_frame_q_c && in_frame_d_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_LINE;
      sync_q         <= 2'b11;
      tcnt_q         <= '0;
      bitcnt_q       <= '0;
      shreg_q        <= '0;
      smp_q          <= 3'b111;
      rx_byte_q      <= '0;
      received_q     <= 1'b0;
      is_receiving_q <= 1'b0;
      recv_error_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      sync_q         <= sync_d;
      tcnt_q         <= tcnt_d;
      bitcnt_q       <= bitcnt_d;
      shreg_q        <= shreg_d;
      smp_q          <= smp_d;
      rx_byte_q      <= rx_byte_d;
      received_q     <= received_d;
      is_receiving_q <= is_receiving_d;
      recv_error_q   <= recv_error_d;
    end
  end

  assign bus.rx_byte      = rx_byte_q;
  assign bus.received     = received_q;
  assign bus.is_receiving = is_receiving_q;
  assign bus.recv_error   = recv_error_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive half of the UART link: it turns the asynchronous `rx` pin into validated bytes. Each good frame (8N1, LSB first) gives one `rx_byte` value and a one-cycle `received` strobe. A bad stop bit gives a one-cycle `recv_error` strobe. The block sits between the board pin and the buffering/echo logic in the top level, which reads `received`, `rx_byte`, `is_receiving` and `recv_error`.

## Interface
- `CLK_FREQ`, 50_000_000, system clock in Hz.
- `BAUD`, 9600, line rate.
- `OVERSAMPLE`, 16, ticks per bit. Fixed at 16; any other value is unsupported.
- `DIV`, `CLK_FREQ/(BAUD*OVERSAMPLE)`, clocks per tick. Integer truncation: 325 at the defaults.
- `clk  in  1`: single clock. All logic is on its rising edge.
- `rst  in  1`: reset, asynchronous and active-high.
- `rx  in  1`: serial line. Idles high. Asynchronous to `clk`.
- `rx_byte  out  8`: last good byte. Reset value 0x00.
- `received  out  1`: one-cycle strobe when `rx_byte` has just been updated. Reset value 0.
- `is_receiving  out  1`: high while a frame is in progress. Reset value 0.
- `recv_error  out  1`: one-cycle strobe on a framing error. Reset value 0.

## Operation
- **Synchronizer:** `rx` passes through 2 flops, both reset to 1. All decisions use the synchronized value `rxs`.
- **Tick generator:**
  - Counts 0..DIV-1 and emits `tick` on DIV-1.
  - Cleared to 0 on entry to S_START, so tick k (k = 0, 1, …) occurs DIV*(k+1) clocks after entry.
  - The count `tcnt` (0..15, 4 bits, wraps) advances on each tick and is also cleared on S_START entry.
- **Bit decision:** on ticks with `tcnt` = 7, 8 and 9, `rxs` is recorded. The bit value is the majority of these 3 samples (2-of-3).
- **States:**
  - S_LINE (reset state): wait for `rxs`=1, then go to S_IDLE. Prevents a line held low at reset release from being read as a start bit.
  - S_IDLE: `rxs`=0 → S_START.
  - S_START: at `tcnt`=15:
    - Majority 1 → false start, go to S_IDLE with no strobes.
    - Majority 0 → S_DATA, with `bitcnt` = 0.
  - S_DATA: at `tcnt`=15, `shreg` <= {maj, shreg[7:1]} and `bitcnt` increments.
    - After `bitcnt` reaches 7 (the 8th bit) → S_STOP.
  - S_STOP: decision at `tcnt`=9, not 15, leaving half a bit of margin for a back-to-back start.
    - Majority 1: `rx_byte` <= `shreg`, pulse `received`, → S_IDLE.
    - Majority 0: pulse `recv_error`, leave `rx_byte` unchanged, → S_LINE.
- **`is_receiving`** = state ∈ {S_START, S_DATA, S_STOP}. It is a registered decode.
- No parity and no break detection beyond the framing error.
- **Simultaneous events:**
  - `received` and `recv_error` are never high in the same cycle.
  - A new start bit seen in S_IDLE in the cycle right after `received` is accepted.
- **Reset mid-frame:** all state and outputs go to their reset values immediately. The partial frame is discarded with no strobes. The block stays in S_LINE until the line is high.

## Timing
- Pin falling edge → S_START entry: 3 clocks (2 synchronizer + 1 state).
- S_START entry → `received` high: 154*DIV clocks, which is 50,050 at the defaults. Equivalently, 9 bits × 16 ticks plus 10 ticks.
- `rx_byte` is valid in the same cycle as `received` and holds until the next good frame.
- `recv_error` has the same timing as `received`.
- `is_receiving` rises 1 clock after S_START entry and falls together with the strobe.
- Minimum accepted idle between frames: 0 bit times, because of the half-bit stop margin.
- Baud tolerance: sampling at ticks 7–9 tolerates at least ±3% rate mismatch over a frame.

## Structure
- **Shared package `uart_pkg`:**
  - State encoding: S_LINE, S_IDLE, S_START, S_DATA, S_STOP (3 bits).
  - `OVERSAMPLE` = 16.
  - Sample tick indices 7/8/9.
  - Stop-decision tick 9.
  - Later reused by the transmit side.
- **Sub-module `baud_tick_gen`:** parameter DIV; ports `clk`, `rst`, `clear`, output `tick`. The transmit path later instantiates it with `clear` tied low.
- Synchronizer, majority voter, FSM and shift register live in `uart_rx`.

## Test plan
- **Good frame:** drive 0x61 at 9600 baud, framed 8N1 → exactly one `received` pulse; `rx_byte`=0x61; `recv_error` stays 0; `is_receiving` high for about 9.6 bit times.
- **Edge data values:** drive 0x00, then 0xFF, then 0x55 back-to-back with no idle → three `received` pulses, with `rx_byte` = 0x00, 0xFF, 0x55 in order.
- **False start:** pull `rx` low for 2,000 clocks, which is under half a bit (2,600 clocks) → `is_receiving` pulses briefly; no `received`, no `recv_error`; the following frame 0x41 is received correctly.
- **Framing error:** drive 0x5A with stop bit = 0 and hold the line low for 3 more bit times, then high, then send 0x42 → one `recv_error` pulse; `rx_byte` keeps its previous value; no strobe while the line is low; then `received` with 0x42.
- **Reset mid-frame:** assert `rst` during data bit 4 of 0x33 while the line is low → outputs are immediately 0x00/0/0/0; after release with the line still low, no activity; once the line is high, frame 0x34 is received.
- **Baud mismatch:** drive 0xA5 at 9,888 baud and then at 9,312 baud (±3%) → both received as 0xA5 with no error.
